quad_mem_arbiter: RTL and testbench

- Round-robin arbiter sharing one data-memory port between the four cores of the quad-core system.
- Sits between the per-core load/store request outputs and the single shared data memory.
- Allows one outstanding memory transaction at a time, using a req/ack handshake on both sides.
- Returns read data and completion to the owning core only.

---
 rtl/quad_core_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/quad_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_quad_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_core_pkg.sv
// Shared types and default sizes for the quad-core memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package quad_core_pkg;

    localparam int NUM_CORES = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;

    typedef logic [$clog2(NUM_CORES)-1:0] core_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first asserted request scanning upward from rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_priority_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_CORES-1:0] gnt,
    output logic [IDX_W-1:0]     idx,
    output logic                 any_req
);

    logic [IDX_W-1:0] cand;

    // Scan from rr_ptr; NUM_CORES is a power of two so the index wraps by truncation.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int off = 0; off < NUM_CORES; off++) begin
            cand = rr_ptr + IDX_W'(off);
            if (!any_req && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_CORES cores; optional ARB_TIMEOUT_EN.
// Latency: req at edge 0 -> gnt/mem_req in cycle 1; mem_ack at edge k -> rvalid in cycle k+1.
// Backpressure: one transaction in flight; other requests hold core_req until their core_gnt.
module quad_mem_arbiter
    import quad_core_pkg::*;
#(
    parameter int NUM_CORES   = quad_core_pkg::NUM_CORES,
    parameter int ADDR_W      = quad_core_pkg::ADDR_W,
    parameter int DATA_W      = quad_core_pkg::DATA_W
`ifdef ARB_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        core_err,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = $clog2(NUM_CORES);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       owner;
    logic [NUM_CORES-1:0]   win_gnt;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic                   do_load;
    logic                   do_done;
    logic                   do_tmo;

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req     (core_req),
        .rr_ptr  (rr_ptr),
        .gnt     (win_gnt),
        .idx     (win_idx),
        .any_req (win_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // Counts BUSY cycles without mem_ack; cleared whenever a new transaction starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (do_load) begin
            tmo_cnt <= '0;
        end else if (state == BUSY && !mem_ack) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // This edge would be the TIMEOUT_CYC-th BUSY cycle without an ack.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus one-cycle action strobes; mem_ack wins over a same-edge timeout.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_done   = 1'b0;
        do_tmo    = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_nxt = BUSY;
                    do_load   = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                    do_done   = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = RESP;
                    do_tmo    = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs: latch the winner into mem_*, pulse gnt/rvalid for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            owner       <= '0;
            core_gnt    <= '0;
            core_rvalid <= '0;
            core_rdata  <= '0;
            core_err    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            core_gnt    <= '0;
            core_rvalid <= '0;
            if (state == RESP) begin
                core_rdata <= '0;
                core_err   <= 1'b0;
            end
            if (do_load) begin
                mem_req   <= 1'b1;
                mem_we    <= core_we[win_idx];
                mem_addr  <= core_addr[win_idx*ADDR_W +: ADDR_W];
                mem_wdata <= core_wdata[win_idx*DATA_W +: DATA_W];
                core_gnt  <= win_gnt;
                owner     <= win_idx;
                rr_ptr    <= win_idx + IDX_W'(1);
            end
            if (do_done) begin
                mem_req     <= 1'b0;
                core_rdata  <= mem_we ? '0 : mem_rdata;
                core_rvalid <= NUM_CORES'(1) << owner;
                core_err    <= 1'b0;
            end
            if (do_tmo) begin
                mem_req     <= 1'b0;
                core_rdata  <= '0;
                core_rvalid <= NUM_CORES'(1) << owner;
                core_err    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quad_mem_arbiter.sv
// Bench for quad_mem_arbiter: directed scenarios plus randomized traffic vs. a transaction model.
// Latency: model predicts gnt one cycle after an idle edge with requests, rvalid one cycle after ack.
// Backpressure: memory model acks after a random or forced delay; cores hold req until gnt.
module tb_quad_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 64;

    logic              clk;
    logic              reset;
    logic [N-1:0]      core_req;
    logic [N-1:0]      core_we;
    logic [N*AW-1:0]   core_addr;
    logic [N*DW-1:0]   core_wdata;
    logic [N-1:0]      core_gnt;
    logic [N-1:0]      core_rvalid;
    logic [DW-1:0]     core_rdata;
    logic              core_err;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;

    quad_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model of the shared port.
    int          ptr;
    bit          busy_m;
    bit          acked;
    int          owner_m;
    int          bcnt;
    logic        t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wd;
    int          delay;
    int          fixed_delay;
    bit          mem_auto;
    bit          ack_junk;
    bit          force_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr     = 0;
        busy_m  = 0;
        acked   = 0;
        owner_m = 0;
        bcnt    = 0;
        delay   = 0;
    endtask

    // One clock: sample inputs at the edge, predict, check at the falling edge, then drive.
    task automatic cycle();
        logic [N-1:0] req_s;
        logic         ack_s;
        logic [31:0]  rd_s;
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        logic [31:0]  erd;
        logic         eerr;
        int           w;
        @(posedge clk);
        req_s = core_req;
        ack_s = mem_ack;
        rd_s  = mem_rdata;
        @(negedge clk);
        eg = '0; ev = '0; erd = '0; eerr = 1'b0;
        if (!busy_m) begin
            if (req_s != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (ptr + k) % N;
                    if (w < 0 && req_s[c]) w = c;
                end
                eg      = N'(1 << w);
                owner_m = w;
                ptr     = (w + 1) % N;
                busy_m  = 1;
                acked   = 0;
                bcnt    = 0;
                t_we    = core_we[w];
                t_addr  = core_addr[w*AW +: AW];
                t_wd    = core_wdata[w*DW +: DW];
                delay   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
            end
        end else if (!acked) begin
            if (ack_s) begin
                ev    = N'(1 << owner_m);
                erd   = t_we ? 32'h0 : rd_s;
                acked = 1;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
                bcnt++;
                if (bcnt == TMO) begin
                    ev    = N'(1 << owner_m);
                    erd   = 32'h0;
                    eerr  = 1'b1;
                    acked = 1;
                end
            end
`endif
        end else begin
            busy_m = 0;
        end

        chk("gnt", core_gnt, eg);
        chk("rvalid", core_rvalid, ev);
        chk("mem_req", mem_req, (busy_m && !acked));
        chk("err", core_err, eerr);
        if (busy_m && !acked) begin
            chk("mem_we", mem_we, t_we);
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_wdata", mem_wdata, t_wd);
        end
        if (ev != '0) chk("rdata", core_rdata, erd);

        for (int i = 0; i < N; i++) if (eg[i]) core_req[i] = 1'b0;
        mem_rdata = $urandom;
        if (busy_m && !acked) begin
            if (mem_auto && delay == 0) begin
                mem_ack = 1'b1;
                if (force_rd) mem_rdata = 32'hDEADBEEF;
            end else begin
                mem_ack = 1'b0;
                if (delay > 0) delay--;
            end
        end else begin
            mem_ack = ack_junk ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            cycle();
            if (!busy_m && core_req == '0) done = 1;
        end
        if (!done) chk("wait_bound", 1'b0, 1'b1);
    endtask

    task automatic set_core(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        core_req[i]            = 1'b1;
        core_we[i]             = we;
        core_addr[i*AW +: AW]  = a;
        core_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", core_gnt, 4'h0);
        chk("rst_rvalid", core_rvalid, 4'h0);
        chk("rst_rdata", core_rdata, 32'h0);
        chk("rst_err", core_err, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset       = 1'b1;
        core_req    = '0;
        core_we     = '0;
        core_addr   = '0;
        core_wdata  = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        fixed_delay = -1;
        mem_auto    = 1;
        ack_junk    = 0;
        force_rd    = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // All four request together: served 0,1,2,3 with a quick ack.
        fixed_delay = 0;
        for (int i = 0; i < N; i++) set_core(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        wait_idle(60);

        // Core 1 store vs core 3 load with rr_ptr back at 0.
        core_req = '0;
        set_core(1, 1'b1, 32'h40, 32'hCAFE);
        set_core(3, 1'b0, 32'h80, 32'h0);
        fixed_delay = 2;
        wait_idle(40);

        // Core 2 alone loads 0x100, memory answers after 5 BUSY cycles.
        set_core(2, 1'b0, 32'h100, 32'h0);
        fixed_delay = 5;
        force_rd    = 1;
        wait_idle(40);
        force_rd    = 0;

        // Reset mid-transaction with core 0 as owner.
        set_core(0, 1'b0, 32'h200, 32'h0);
        mem_auto = 0;
        cycle();
        cycle();
        cycle();
        #2 reset = 1'b1;
        #1 chk("async_mem_req", mem_req, 1'b0);
        chk("async_gnt", core_gnt, 4'h0);
        @(negedge clk);
        reset    = 1'b0;
        mem_auto = 1;
        model_reset();
        fixed_delay = -1;
        ack_junk    = 1;
        for (int c = 0; c < 4; c++) cycle();
        set_core(0, 1'b1, 32'h300, 32'h11);
        set_core(1, 1'b0, 32'h304, 32'h22);
        wait_idle(40);

        // Randomized traffic with stray acks outside BUSY.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (!core_req[i] && $urandom_range(0, 99) < 35)
                    set_core(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            cycle();
        end
        core_req = '0;
        wait_idle(80);

        // No ack from memory: times out if enabled, otherwise mem_req holds.
        ack_junk = 0;
        mem_auto = 0;
        set_core(0, 1'b0, 32'h400, 32'h0);
        cycle();
        set_core(1, 1'b0, 32'h404, 32'h0);
        for (int c = 0; c < TMO + 40; c++) cycle();
`ifndef ARB_TIMEOUT_EN
        chk("hold_mem_req", mem_req, 1'b1);
`endif
        core_req = '0;
        @(negedge clk);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
